// File: rtl/result_serializer_if.sv
// Shared defaults for the result serializer and its handshake interface.
package result_serializer_pkg;
  parameter int N        = 4;
  parameter int NUM_BITS = 8;
endpackage

// Load side, output stream and status of the result serializer, bundled.
// The slave modport is the serializer itself; master is whoever feeds and
// drains it.
interface result_serializer_if #(
  parameter int N        = result_serializer_pkg::N,
  parameter int NUM_BITS = result_serializer_pkg::NUM_BITS
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic                         load_valid_i;
  logic                         load_ready_o;
  logic [N-1:0][NUM_BITS-1:0]   load_data_i;
  logic                         abort_i;
  logic [NUM_BITS-1:0]          data_o;
  logic                         valid_o;
  logic                         ready_i;
  logic                         last_o;
  logic [IDX_W-1:0]             idx_o;
  logic                         busy_o;

  modport slave (
    input  load_valid_i, load_data_i, abort_i, ready_i,
    output load_ready_o, data_o, valid_o, last_o, idx_o, busy_o
  );

  modport master (
    output load_valid_i, load_data_i, abort_i, ready_i,
    input  load_ready_o, data_o, valid_o, last_o, idx_o, busy_o
  );
endinterface

// File: rtl/result_serializer.sv
// Parallel-to-serial drain for the PE result path. A whole vector is captured
// in one handshake and replayed oldest-first (element N-1 down to 0), which
// undoes the order reversal of the PE capture shift chain.

// One buffer word: captured on a load, cleared on reset.
module result_serializer_lane #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] word_q, word_d;

  // Hold unless a new vector is being loaded.
  always_comb begin
    word_d = word_q;
    if (load_en_i) word_d = d_i;
  end

  // Word register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) word_q <= '0;
    else         word_q <= word_d;
  end

  assign q_o = word_q;
endmodule

module result_serializer #(
  parameter int N        = result_serializer_pkg::N,
  parameter int NUM_BITS = result_serializer_pkg::NUM_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  result_serializer_if.slave   bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [N-1:0][NUM_BITS-1:0]  word_buf;
  logic                        load_ready;
  logic                        load_fire;

  // Vector buffer, one lane per word; all lanes capture together.
  for (genvar g = 0; g < N; g++) begin : g_lane
    result_serializer_lane #(.W(NUM_BITS)) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_en_i (load_fire),
      .d_i       (bus.load_data_i[g]),
      .q_o       (word_buf[g])
    );
  end

  // Ready is combinational so a new vector can land on the final beat of
  // the current one; abort suppresses that reload.
  always_comb begin
    load_ready = (state_q == IDLE) ||
                 (idx_q == '0 && bus.ready_i && !bus.abort_i);
    load_fire  = bus.load_valid_i && load_ready;
  end

  // Next state and down-counter. A load only fires in SEND on the last
  // accepted beat, so it is handled first and covers the reload case.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (load_fire) begin
      state_d = SEND;
      idx_d   = IDX_TOP;
    end else if (state_q == SEND) begin
      if (bus.abort_i) begin
        state_d = IDLE;
      end else if (bus.ready_i) begin
        if (idx_q != '0) idx_d   = idx_q - IDX_W'(1);
        else             state_d = IDLE;
      end
    end
  end

  // State and index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Stream outputs: a mux of registers, forced to zero while idle.
  always_comb begin
    bus.load_ready_o = load_ready;
    bus.busy_o       = (state_q == SEND);
    bus.valid_o      = (state_q == SEND);
    bus.data_o       = '0;
    bus.idx_o        = '0;
    bus.last_o       = 1'b0;
    if (state_q == SEND) begin
      bus.data_o = word_buf[idx_q];
      bus.idx_o  = idx_q;
      bus.last_o = (idx_q == '0);
    end
  end
endmodule
